// File: rtl/mem_data_pkg.sv
// Shared types and helpers for the load/store data memory.
// Optional MEMDATA_BOUNDS_EN (see mem_data_ctrl) makes out-of-range addresses fault.
package mem_data_pkg;

    localparam int MAX_RD_LAT = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Extend right-aligned load lanes; uns only matters for sub-word sizes.
    function automatic logic [31:0] load_extend(input size_e sz, input logic uns,
                                                input logic [31:0] lanes);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {{24{~uns & lanes[7]}}, lanes[7:0]};
            SZ_HALF: res = {{16{~uns & lanes[15]}}, lanes[15:0]};
            SZ_WORD: res = lanes;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_data_array.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read.
module mem_data_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [2**ADDR_W];

    // Byte-lane write; contents intentionally have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_data_ctrl.sv
// Load/store data memory controller with valid/ready handshake and RD_LAT latency.
// Define MEMDATA_BOUNDS_EN to fault accesses whose address exceeds the array.
module mem_data_ctrl
    import mem_data_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = $clog2(MAX_RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;
    logic [31:0]      res_data_r;
    logic             res_err_r;

    size_e       size_s;
    logic        accept_s;
    logic        misalign_s;
    logic        bounds_s;
    logic        fault_s;
    logic [3:0]  be_s;
    logic [31:0] wlanes_s;
    logic [31:0] rdata_s;
    logic [31:0] result_s;
    logic        we_s;

    assign size_s   = size_e'(req_size);
    assign accept_s = req_valid && req_ready_r;

`ifdef MEMDATA_BOUNDS_EN
    assign bounds_s = (req_addr >> (ADDR_W + 2)) != 32'd0;
`else
    logic unused_upper_s;
    assign bounds_s       = 1'b0;
    assign unused_upper_s = ^(req_addr >> (ADDR_W + 2));
`endif

    // Alignment check and little-endian store lane steering.
    always_comb begin
        misalign_s = 1'b1;
        be_s       = 4'b0000;
        wlanes_s   = 32'd0;
        case (size_s)
            SZ_BYTE: begin
                misalign_s = 1'b0;
                be_s       = 4'b0001 << req_addr[1:0];
                wlanes_s   = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                misalign_s = req_addr[0];
                be_s       = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes_s   = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                misalign_s = |req_addr[1:0];
                be_s       = 4'b1111;
                wlanes_s   = req_wdata;
            end
            default: begin
                misalign_s = 1'b1;
                be_s       = 4'b0000;
                wlanes_s   = 32'd0;
            end
        endcase
    end

    assign fault_s = misalign_s | bounds_s;
    assign we_s    = accept_s && req_we && !fault_s;

    mem_data_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we_s),
        .be    (be_s),
        .addr  (req_addr[ADDR_W+1:2]),
        .wdata (wlanes_s),
        .rdata (rdata_s)
    );

    // Load data is formed at acceptance; stores and faults return zero.
    always_comb begin
        if (req_we || fault_s) begin
            result_s = 32'd0;
        end else begin
            result_s = load_extend(size_s, req_unsigned,
                                   rdata_s >> {req_addr[1:0], 3'b000});
        end
    end

    // Handshake FSM; the result is parked in res_* until the latency expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            res_data_r  <= 32'd0;
            res_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        res_data_r  <= result_s;
                        res_err_r   <= fault_s;
                        if (RD_LAT == 0) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= result_s;
                            rsp_err_r   <= fault_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r >= LAT_C) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= res_data_r;
                        rsp_err_r   <= res_err_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed bench: instance 0 is ADDR_W=10/RD_LAT=1, instance 1 is ADDR_W=4/RD_LAT=3.
module tb_mem_data_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    mem_data_ctrl #(.ADDR_W(10), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_data_ctrl #(.ADDR_W(4), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; request fields are scrambled right after acceptance.
    task automatic access(input int d, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                          input logic [31:0] exp_data, input logic exp_err, input string tag);
        int k;
        check({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size; req_unsigned[d] = uns;
        req_addr[d] = addr; req_wdata[d] = wdata;
        tick();
        req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b11; req_unsigned[d] = ~uns;
        req_addr[d] = 32'hFFFF_FFFF; req_wdata[d] = 32'h0;
        k = 0;
        while (rsp_valid[d] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " rdata"}, rsp_rdata[d], exp_data);
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        check({tag, " rsp_valid drop"}, 32'(rsp_valid[d]), 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset req_ready", 32'(req_ready[d]), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset rsp_rdata", rsp_rdata[d], 32'd0);
            check("reset rsp_err", 32'(rsp_err[d]), 32'd0);
        end

        // RD_LAT=1 functional sequence
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, "st word 0x10");
        access(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, "ld word 0x10");
        access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA7F, 1, 32'h0, 1'b0, "st byte 0x13");
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h7FADBEEF, 1'b0, "ld word after byte");
        access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'hFFFFFFBE, 1'b0, "ld byte signed");
        access(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 32'h000000BE, 1'b0, "ld byte unsigned");
        access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'h00007FAD, 1'b0, "ld half hi signed");
        access(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1, 32'hFFFFBEEF, 1'b0, "ld half lo signed");
        access(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 32'h0000BEEF, 1'b0, "ld half lo unsigned");

        // Faults
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b0, "init word 0x20");
        access(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 32'h0, 1'b1, "ld half misaligned");
        access(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 1, 32'h0, 1'b1, "st word misaligned");
        access(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1'b1, "st reserved size");
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b0, "ld word 0x20 unchanged");
        access(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b1, "ld reserved size");
        access(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h5555ABCD, 1, 32'h0, 1'b0, "st half 0x22");
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'hABCD0000, 1'b0, "ld word after half");
`ifdef MEMDATA_BOUNDS_EN
        access(0, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1, 32'h0, 1'b1, "ld out of range w10");
`else
        access(0, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1, 32'h7FADBEEF, 1'b0, "ld wrap w10");
`endif

        // RD_LAT=3 with consumer stall and a blocked second request
        access(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 3, 32'h0, 1'b0, "st word 0x00 lat3");
        access(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11111111, 3, 32'h0, 1'b0, "st word 0x04 lat3");
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h0;
        tick();
        req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("stall latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
            req_addr[1] = 32'h4; req_wdata[1] = 32'h0BAD0BAD;
            tick();
            check("stall req_ready", 32'(req_ready[1]), 32'd0);
            check("stall rsp_valid", 32'(rsp_valid[1]), 32'd1);
            check("stall rsp_rdata", rsp_rdata[1], 32'hCAFEF00D);
            check("stall rsp_err", 32'(rsp_err[1]), 32'd0);
        end
        req_valid[1] = 1'b0; req_we[1] = 1'b0; rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        check("stall release rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("stall release req_ready", 32'(req_ready[1]), 32'd1);
        tick();
        access(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 3, 32'h11111111, 1'b0, "ld 0x04 not overwritten");

        // Reset while the store is in WAIT
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
        req_addr[1] = 32'hC; req_wdata[1] = 32'h13572468;
        tick();
        req_valid[1] = 1'b0; req_we[1] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[1] === 1'b1) seen = 1'b1;
        end
        check("reset abort no rsp", 32'(seen), 32'd0);
        check("reset abort req_ready", 32'(req_ready[1]), 32'd1);
        access(1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 3, 32'h13572468, 1'b0, "ld store before reset");

`ifdef MEMDATA_BOUNDS_EN
        access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'h0, 1'b1, "ld 0x40 out of range");
`else
        access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hCAFEF00D, 1'b0, "ld 0x40 wraps");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
